sng_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one SNG between N_REQ requesters.
- Each accepted request loads a binary operand into the SNG and pulses its start.
- It then captures SN_LEN stream bits into a parallel word and pulses stop.
- It returns the word to the winning requester with a one-cycle valid.
- Sits between the NN-layer operand fetch logic and the SNG instance.

---
 rtl/sng_arb.sv | 202 ++++++++++++++++++++
 tb/tb_sng_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sng_arb.sv
// sng_arb: round-robin arbiter and sequencer sharing one SNG between N_REQ
// requesters. A granted request loads its binary operand into the SNG, pulses
// start, captures SN_LEN stream bits into a parallel word, pulses stop, and
// returns the word tagged with the owner index under a one-cycle valid.
//
// Ports:
//   i_clk_arb    clock, rising edge
//   i_rst_arb    synchronous reset, active-high
//   i_req_arb    request vector (level, held until granted)
//   i_x_arb      packed operands, requester k at [k*BN_W +: BN_W]
//   o_gnt_arb    one-hot grant pulse, coincident with START
//   o_busy_arb   high whenever the sequencer is not idle
//   o_start_sng  SNG start pulse
//   o_stop_sng   SNG stop pulse
//   o_x_sng      operand presented to the SNG, held from START through DONE
//   i_sn_bit     stream bit from the SNG
//   o_stream_arb captured stream, bit 0 is the first sample
//   o_valid_arb  one-cycle pulse: o_stream_arb / o_owner_arb are fresh
//   o_owner_arb  index of the requester owning o_stream_arb
//
// Optional build macro: SNG_ARB_ZERO_SKIP_EN
//   When defined, a winner whose operand is zero bypasses the SNG entirely:
//   IDLE goes straight to DONE, the result is an all-zero stream and no
//   start/stop pulses are issued.
module sng_arb #(
  parameter int N_REQ  = 4,
  parameter int BN_W   = 4,
  parameter int SN_LEN = 8,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    i_clk_arb,
  input  logic                    i_rst_arb,
  input  logic [N_REQ-1:0]        i_req_arb,
  input  logic [N_REQ*BN_W-1:0]   i_x_arb,
  output logic [N_REQ-1:0]        o_gnt_arb,
  output logic                    o_busy_arb,
  output logic                    o_start_sng,
  output logic                    o_stop_sng,
  output logic [BN_W-1:0]         o_x_sng,
  input  logic                    i_sn_bit,
  output logic [SN_LEN-1:0]       o_stream_arb,
  output logic                    o_valid_arb,
  output logic [ID_W-1:0]         o_owner_arb
);

  localparam int CNT_W = $clog2(SN_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [ID_W-1:0]   ptr_q,    ptr_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [BN_W-1:0]   x_q,      x_d;
  logic [ID_W-1:0]   own_q,    own_d;
  logic [N_REQ-1:0]  gnt_q,    gnt_d;
  logic [SN_LEN-1:0] buf_q,    buf_d;
  logic [SN_LEN-1:0] stream_q, stream_d;
  logic [ID_W-1:0]   owner_q,  owner_d;
  logic              skip_q,   skip_d;

  // Arbitration result for the current cycle
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [BN_W-1:0]   win_x;
  logic [2*N_REQ-1:0] req_rot;
  logic [ID_W:0]     win_sum;

  // Pointer after serving requester id, wrapping N_REQ-1 -> 0.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  // Rotate the doubled request vector so bit 0 corresponds to the pointer;
  // the lowest set bit of the rotated view is the round-robin winner.
  always_comb begin
    win_vld = 1'b0;
    win_sum = '0;
    req_rot = {i_req_arb, i_req_arb} >> ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      end
    end
    if (win_sum >= (ID_W+1)'(N_REQ)) begin
      win_sum = win_sum - (ID_W+1)'(N_REQ);
    end
    win_id = win_sum[ID_W-1:0];
  end

  always_comb begin
    win_x = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == ID_W'(k)) begin
        win_x = i_x_arb[k*BN_W +: BN_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    own_d    = own_q;
    gnt_d    = '0;
    buf_d    = buf_q;
    stream_d = stream_q;
    owner_d  = owner_q;
    skip_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          x_d   = win_x;
          own_d = win_id;
          gnt_d = N_REQ'(1) << win_id;
`ifdef SNG_ARB_ZERO_SKIP_EN
          // Zero operand: the stream is known to be all zeros, skip the SNG.
          if (win_x == '0) begin
            state_d  = S_DONE;
            skip_d   = 1'b1;
            stream_d = '0;
            owner_d  = win_id;
            ptr_d    = ptr_after(win_id);
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        buf_d[cnt_q] = i_sn_bit;
        cnt_d        = cnt_q + CNT_W'(1);
        // The last sample goes straight into the output shadow so the
        // visible result only changes on DONE entry.
        if (cnt_q == CNT_W'(SN_LEN - 1)) begin
          state_d  = S_DONE;
          stream_d = buf_d;
          owner_d  = own_q;
          ptr_d    = ptr_after(own_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_arb) begin
    if (i_rst_arb) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      own_q    <= '0;
      gnt_q    <= '0;
      stream_q <= '0;
      owner_q  <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      own_q    <= own_d;
      gnt_q    <= gnt_d;
      stream_q <= stream_d;
      owner_q  <= owner_d;
      skip_q   <= skip_d;
    end
  end

  // Capture buffer is pure data and only read after a full RUN pass.
  always_ff @(posedge i_clk_arb) begin
    buf_q <= buf_d;
  end

  assign o_gnt_arb    = gnt_q;
  assign o_busy_arb   = (state_q != S_IDLE);
  assign o_start_sng  = (state_q == S_START);
  assign o_stop_sng   = (state_q == S_DONE) && !skip_q;
  assign o_valid_arb  = (state_q == S_DONE);
  assign o_x_sng      = x_q;
  assign o_stream_arb = stream_q;
  assign o_owner_arb  = owner_q;

endmodule

// File: tb/tb_sng_arb.sv
module tb_sng_arb;
  localparam int N_REQ  = 4;
  localparam int BN_W   = 4;
  localparam int SN_LEN = 8;
  localparam int ID_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*BN_W-1:0] xv;
  logic                  sn_bit;
  logic [N_REQ-1:0]      gnt;
  logic                  busy, start, stop, valid;
  logic [BN_W-1:0]       x_sng;
  logic [SN_LEN-1:0]     stream;
  logic [ID_W-1:0]       owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc, vld_cyc;

  // Reference model state: round-robin pointer and last published result.
  int                m_ptr;
  logic [SN_LEN-1:0] m_stream;
  int                m_owner;

  sng_arb #(.N_REQ(N_REQ), .BN_W(BN_W), .SN_LEN(SN_LEN), .ID_W(ID_W)) dut (
    .i_clk_arb(clk), .i_rst_arb(rst), .i_req_arb(req), .i_x_arb(xv),
    .o_gnt_arb(gnt), .o_busy_arb(busy), .o_start_sng(start), .o_stop_sng(stop),
    .o_x_sng(x_sng), .i_sn_bit(sn_bit), .o_stream_arb(stream),
    .o_valid_arb(valid), .o_owner_arb(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // First requester at or after pointer p, with wrap; -1 if none.
  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    int w;
    w = -1;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (p + i) % N_REQ;
      if (w < 0 && r[k]) w = k;
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    sn_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_stream = '0;
    m_owner = 0;
  endtask

  // Called at a negedge in IDLE with req/xv already driven.
  // Returns at the negedge of the IDLE cycle following DONE.
  task automatic job(input logic [SN_LEN-1:0] bits, input bit chg,
                     input bit release_win, output int own_o);
    int own;
    logic [BN_W-1:0] ex;
    logic [N_REQ-1:0] gx;
    own = pick(req, m_ptr);
    own_o = own;
    ex = xv[own*BN_W +: BN_W];
    gx = '0;
    gx[own] = 1'b1;
    @(negedge clk);
    gnt_cyc = cyc;
    checks++; if (gnt !== gx) begin errors++; $display("FAIL grant: got %b expected %b", gnt, gx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start: got %b expected 1", busy); end
    checks++; if (x_sng !== ex) begin errors++; $display("FAIL x_sng_start: got %0d expected %0d", x_sng, ex); end
    if (release_win) req[own] = 1'b0;
`ifdef SNG_ARB_ZERO_SKIP_EN
    if (ex == '0) begin
      vld_cyc = cyc;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL skip_valid: got %b expected 1", valid); end
      checks++; if ({start, stop} !== 2'b00) begin errors++; $display("FAIL skip_start_stop: got %b expected 00", {start, stop}); end
      checks++; if (stream !== '0) begin errors++; $display("FAIL skip_stream: got %h expected 0", stream); end
      checks++; if (owner !== ID_W'(own)) begin errors++; $display("FAIL skip_owner: got %0d expected %0d", owner, own); end
      m_stream = '0;
      m_owner = own;
      m_ptr = (own + 1) % N_REQ;
      @(negedge clk);
      checks++; if ({busy, valid, stop} !== 3'b000) begin errors++; $display("FAIL skip_idle: got %b expected 000", {busy, valid, stop}); end
      return;
    end
`endif
    checks++; if ({start, valid, stop} !== 3'b100) begin errors++; $display("FAIL start_pulse: got %b expected 100", {start, valid, stop}); end
    for (int k = 0; k < SN_LEN; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, start, valid, stop, gnt} !== {4'b1000, {N_REQ{1'b0}}} || x_sng !== ex || stream !== m_stream || owner !== ID_W'(m_owner)) begin
        errors++;
        $display("FAIL run_cycle%0d: got busy/start/valid/stop=%b gnt=%b x=%0d stream=%h owner=%0d expected 1000 gnt=0 x=%0d stream=%h owner=%0d",
                 k, {busy, start, valid, stop}, gnt, x_sng, stream, owner, ex, m_stream, m_owner);
      end
      if (chg) begin
        req = N_REQ'($urandom);
        xv = (N_REQ*BN_W)'($urandom);
      end
      sn_bit = bits[k];
    end
    @(negedge clk);
    vld_cyc = cyc;
    if (chg) req = '0;
    checks++; if ({valid, stop, start} !== 3'b110) begin errors++; $display("FAIL done_pulses: got %b expected 110", {valid, stop, start}); end
    checks++; if (stream !== bits) begin errors++; $display("FAIL stream: got %h expected %h", stream, bits); end
    checks++; if (owner !== ID_W'(own)) begin errors++; $display("FAIL owner: got %0d expected %0d", owner, own); end
    checks++; if (x_sng !== ex) begin errors++; $display("FAIL x_sng_done: got %0d expected %0d", x_sng, ex); end
    m_stream = bits;
    m_owner = own;
    m_ptr = (own + 1) % N_REQ;
    @(negedge clk);
    checks++; if ({busy, valid, stop, gnt} !== {3'b000, {N_REQ{1'b0}}}) begin errors++; $display("FAIL idle_after: got %b expected 0", {busy, valid, stop, gnt}); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", gnt); end
    checks++; if ({busy, start, stop, valid} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {busy, start, stop, valid}); end
    checks++; if (x_sng !== '0) begin errors++; $display("FAIL rst_x: got %0d expected 0", x_sng); end
    checks++; if (stream !== '0) begin errors++; $display("FAIL rst_stream: got %h expected 0", stream); end
    checks++; if (owner !== '0) begin errors++; $display("FAIL rst_owner: got %0d expected 0", owner); end
  endtask

  task automatic test_basic();
    int own;
    req = 4'b0001;
    xv = 16'h0005;
    job(8'hA6, 1'b0, 1'b1, own);
    checks++; if (vld_cyc - gnt_cyc !== SN_LEN + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", vld_cyc - gnt_cyc, SN_LEN + 1); end
    checks++; if (stream !== 8'hA6) begin errors++; $display("FAIL basic_stream_hold: got %h expected a6", stream); end
  endtask

  task automatic test_round_robin();
    int own, prev;
    int exp_own[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    xv = 16'h4321;
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      job(8'(($urandom)), 1'b0, 1'b0, own);
      checks++; if (owner !== ID_W'(exp_own[j])) begin errors++; $display("FAIL rr_owner%0d: got %0d expected %0d", j, owner, exp_own[j]); end
      if (j > 0) begin
        checks++; if (vld_cyc - prev !== SN_LEN + 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected %0d", j, vld_cyc - prev, SN_LEN + 3); end
      end
      prev = vld_cyc;
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    int own;
    // Pointer is 1 here; serving requester 1 moves it to 2.
    req = 4'b0010;
    xv = 16'h7777;
    job(8'h3C, 1'b0, 1'b0, own);
    // Pointer 2, only req[1]: search wraps 2,3,0,1.
    job(8'hC3, 1'b0, 1'b0, own);
    checks++; if (owner !== 2'd1) begin errors++; $display("FAIL wrap_owner: got %0d expected 1", owner); end
    req = 4'b1111;
    job(8'h5A, 1'b0, 1'b0, own);
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL ptr_after_wrap: got %0d expected 2", owner); end
    req = '0;
  endtask

  task automatic test_busy_changes();
    int own;
    req = 4'b1000;
    xv = 16'h9ABC;
    job(8'h81, 1'b1, 1'b0, own);
  endtask

  task automatic test_reset_midrun();
    int own;
    req = 4'b0100;
    xv = 16'h0900;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sn_bit = k[0];
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_stream = '0;
    m_owner = 0;
    checks++;
    if ({gnt, busy, start, stop, valid} !== '0 || x_sng !== '0 || stream !== '0 || owner !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got gnt=%b ctrl=%b x=%0d stream=%h owner=%0d expected all 0", gnt, {busy, start, stop, valid}, x_sng, stream, owner);
    end
    for (int k = 0; k < SN_LEN + 4; k++) begin
      @(negedge clk);
      checks++; if ({valid, stop, busy} !== 3'b000) begin errors++; $display("FAIL aborted_job_%0d: got %b expected 000", k, {valid, stop, busy}); end
    end
    req = 4'b1111;
    xv = 16'h4321;
    job(8'hF0, 1'b0, 1'b0, own);
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL post_reset_owner: got %0d expected 0", owner); end
    req = '0;
  endtask

  task automatic test_zero_operand();
    int own, lat;
    req = 4'b0100;
    xv = 16'h3021;
    job(8'h6D, 1'b0, 1'b1, own);
`ifdef SNG_ARB_ZERO_SKIP_EN
    lat = 0;
`else
    lat = SN_LEN + 1;
`endif
    checks++; if (vld_cyc - gnt_cyc !== lat) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", vld_cyc - gnt_cyc, lat); end
  endtask

  task automatic test_random();
    int own;
    for (int n = 0; n < 24; n++) begin
      req = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      xv = (N_REQ*BN_W)'($urandom);
      job(SN_LEN'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), own);
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    xv = '0;
    sn_bit = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_ptr_wrap();
    test_busy_changes();
    test_reset_midrun();
    test_zero_operand();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
